// File: rtl/layer_out_serializer.sv
// Captures a whole layer of neuron outputs on x_valid and replays them one word per clock,
// neuron 0 first, as the input stream for the next layer.
module layer_out_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  parameter int cntWidth   = $clog2(numNeurons + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons*dataWidth-1:0] x_in,
  input  logic                            x_valid,
  output logic [dataWidth-1:0]            data_out,
  output logic                            data_out_valid,
  output logic                            data_out_last,
  output logic                            busy,
  output logic                            overrun
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                          state_q, state_d;
  logic [numNeurons*dataWidth-1:0] buf_q, buf_d;
  logic [cntWidth-1:0]             idx_q, idx_d;
  logic [dataWidth-1:0]            data_d;
  logic                            valid_d, last_d, busy_d, overrun_d;
  logic                            load;

  // A new frame is taken when idle or while the last word of the current frame is showing.
  assign load = x_valid && ((state_q == IDLE) || data_out_last);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    data_d    = '0;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    busy_d    = 1'b0;
    overrun_d = overrun;
    if (load) begin
      // Word 0 goes straight out; the buffer keeps the remaining words, next one in the low slot.
      buf_d   = x_in >> dataWidth;
      data_d  = x_in[dataWidth-1:0];
      valid_d = 1'b1;
      busy_d  = 1'b1;
      idx_d   = cntWidth'(1);
      state_d = SHIFT;
    end else if (state_q == SHIFT && !data_out_last) begin
      buf_d   = buf_q >> dataWidth;
      data_d  = buf_q[dataWidth-1:0];
      valid_d = 1'b1;
      busy_d  = 1'b1;
      last_d  = (idx_q == cntWidth'(numNeurons - 1));
      idx_d   = idx_q + cntWidth'(1);
      if (x_valid) begin
        overrun_d = 1'b1;
      end
    end else if (state_q == SHIFT) begin
      idx_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      buf_q          <= '0;
      idx_q          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state_q        <= state_d;
      buf_q          <= buf_d;
      idx_q          <= idx_d;
      data_out       <= data_d;
      data_out_valid <= valid_d;
      data_out_last  <= last_d;
      busy           <= busy_d;
      overrun        <= overrun_d;
    end
  end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with a 4-neuron, 16-bit layer.
module tb_layer_out_serializer;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] x_in;
  logic            x_valid;
  logic [DW-1:0]   data_out;
  logic            data_out_valid;
  logic            data_out_last;
  logic            busy;
  logic            overrun;

  int passCount  = 0;
  int checkCount = 0;

  layer_out_serializer #(.numNeurons(N), .dataWidth(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .x_in           (x_in),
    .x_valid        (x_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_last  (data_out_last),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    x_valid = v;
    x_in    = {w3, w2, w1, w0};
  endtask

  task automatic expectOut(input string tag, input logic [DW-1:0] d, input logic v,
                           input logic l, input logic b);
    checkOutput({tag, " data"},  32'(data_out),       32'(d));
    checkOutput({tag, " valid"}, 32'(data_out_valid), 32'(v));
    checkOutput({tag, " last"},  32'(data_out_last),  32'(l));
    checkOutput({tag, " busy"},  32'(busy),           32'(b));
  endtask

  // Expects word 0 of frame f to be showing now; leaves the last word showing on return.
  task automatic checkFrame(input string tag, input logic [N*DW-1:0] f);
    for (int k = 0; k < N; k++) begin
      expectOut($sformatf("%s w%0d", tag, k), f[k*DW +: DW], 1'b1, (k == N-1), 1'b1);
      if (k != N-1) step();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    step();
    step();
    rst = 1'b0;
    expectOut("reset", 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);

    // Single frame with x_in scribbled right after capture.
    applyStimulus(1'b1, 16'h0001, 16'h8000, 16'h7FFF, 16'h1234);
    step();
    applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    checkFrame("single", {16'h1234, 16'h7FFF, 16'h8000, 16'h0001});
    step();
    expectOut("single end", 16'h0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: second pulse while the last word is showing.
    applyStimulus(1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    checkFrame("b2b first", {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    applyStimulus(1'b1, 16'h000A, 16'h000B, 16'h000C, 16'h000D);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    checkFrame("b2b second", {16'h000D, 16'h000C, 16'h000B, 16'h000A});
    step();
    expectOut("b2b end", 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b overrun", 32'(overrun), 32'd0);

    // Overrun: pulse while the second word is showing.
    applyStimulus(1'b1, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    expectOut("ovr w0", 16'h0101, 1'b1, 1'b0, 1'b1);
    step();
    expectOut("ovr w1", 16'h0202, 1'b1, 1'b0, 1'b1);
    checkOutput("ovr before", 32'(overrun), 32'd0);
    applyStimulus(1'b1, 16'hEEEE, 16'hEEEE, 16'hEEEE, 16'hEEEE);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    expectOut("ovr w2", 16'h0303, 1'b1, 1'b0, 1'b1);
    checkOutput("ovr set", 32'(overrun), 32'd1);
    step();
    expectOut("ovr w3", 16'h0404, 1'b1, 1'b1, 1'b1);
    step();
    expectOut("ovr end", 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    expectOut("ovr idle", 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr sticky", 32'(overrun), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("ovr cleared", 32'(overrun), 32'd0);

    // Reset while the second word is showing abandons the frame.
    applyStimulus(1'b1, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    expectOut("rstmid w0", 16'h5555, 1'b1, 1'b0, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expectOut("rstmid after", 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput($sformatf("rstmid idle%0d valid", i), 32'(data_out_valid), 32'd0);
    end
    applyStimulus(1'b1, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    checkFrame("rstmid fresh", {16'hF0F0, 16'h0F0F, 16'hDEF0, 16'h9ABC});
    step();
    expectOut("rstmid fresh end", 16'h0, 1'b0, 1'b0, 1'b0);

    // Reset and x_valid on the same edge: reset wins.
    rst = 1'b1;
    applyStimulus(1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    expectOut("rstprio", 16'h0, 1'b0, 1'b0, 1'b0);
    step();
    expectOut("rstprio next", 16'h0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
